// File: rtl/patch_broadcaster_if.sv
// Sample-memory read port and shared CIM bus write side of the patch broadcaster.
// master = broadcaster, slave = sample memory / bus fabric.
interface patch_broadcaster_if #(
    parameter int unsigned N_STORAGE     = 16,
    parameter int unsigned BUS_OP_WIDTH  = 4,
    parameter int unsigned NUM_CIMS      = 64,
    parameter int unsigned SAMPLE_ADDR_W = 12
);
    logic                        sample_rd_en;
    logic [SAMPLE_ADDR_W-1:0]    sample_rd_addr;
    logic [N_STORAGE-1:0]        sample_rd_data;
    logic                        all_cims_ready;
    logic                        bus_drive;
    logic [BUS_OP_WIDTH-1:0]     bus_op_write;
    logic [3*N_STORAGE-1:0]      bus_data_write;
    logic [$clog2(NUM_CIMS)-1:0] bus_target_or_sender_write;

    modport master (
        output sample_rd_en, sample_rd_addr, bus_drive, bus_op_write,
               bus_data_write, bus_target_or_sender_write,
        input  sample_rd_data, all_cims_ready
    );

    modport slave (
        input  sample_rd_en, sample_rd_addr, bus_drive, bus_op_write,
               bus_data_write, bus_target_or_sender_write,
        output sample_rd_data, all_cims_ready
    );
endinterface

// File: rtl/patch_broadcaster.sv
// Streams EEG patches from sample memory onto the shared CIM bus as broadcast
// patch-load words, with NOP gaps between patches, then waits for CIM readiness.
module patch_broadcaster #(
    parameter int unsigned PATCH_LEN       = 64,
    parameter int unsigned NUM_PATCHES     = 60,
    parameter int unsigned INTER_PATCH_GAP = 96,
    parameter int unsigned READY_TIMEOUT   = 4096,
    parameter int unsigned N_STORAGE       = 16,
    parameter int unsigned BUS_OP_WIDTH    = 4,
    parameter int unsigned NUM_CIMS        = 64,
    parameter int unsigned SAMPLE_ADDR_W   = $clog2(PATCH_LEN*NUM_PATCHES),
    parameter logic [BUS_OP_WIDTH-1:0] NOP_OP   = BUS_OP_WIDTH'(0),
    parameter logic [BUS_OP_WIDTH-1:0] START_OP = BUS_OP_WIDTH'(5),
    parameter logic [BUS_OP_WIDTH-1:0] BCAST_OP = BUS_OP_WIDTH'(6)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    patch_broadcaster_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);
    localparam int unsigned WORD_W  = $clog2(PATCH_LEN+1);
    localparam int unsigned PATCH_W = $clog2(NUM_PATCHES+1);
    localparam int unsigned GAP_W   = $clog2(INTER_PATCH_GAP+1);
    localparam int unsigned WAIT_W  = $clog2(READY_TIMEOUT+1);
    localparam logic [WORD_W-1:0]  WORD_LAST = WORD_W'(PATCH_LEN-1);
    localparam logic [PATCH_W-1:0] PATCH_NUM = PATCH_W'(NUM_PATCHES);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(INTER_PATCH_GAP-1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(READY_TIMEOUT-1);

    typedef enum logic [2:0] {
        S_IDLE, S_BCAST_START, S_STREAM, S_GAP, S_WAIT_READY, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_W-1:0]         word_cnt_q, word_cnt_d;
    logic [PATCH_W-1:0]        patch_cnt_q, patch_cnt_d;
    logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic                      rd_en_q, rd_en_d;
    logic [SAMPLE_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic                      drive_q, drive_d;
    logic [BUS_OP_WIDTH-1:0]   op_q, op_d;
    logic                      stream_q, stream_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      terr_q, terr_d;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        patch_cnt_d = patch_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        terr_d      = terr_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        drive_d     = 1'b0;
        op_d        = NOP_OP;
        stream_d    = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;

        // Transition: decide which state (and counter values) the next cycle shows.
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_BCAST_START;
                        terr_d  = 1'b0;
                    end
                end
                S_BCAST_START: begin
                    state_d    = S_STREAM;
                    word_cnt_d = '0;
                end
                S_STREAM: begin
                    if (word_cnt_q == WORD_LAST) begin
                        state_d     = S_GAP;
                        word_cnt_d  = '0;
                        gap_cnt_d   = '0;
                        patch_cnt_d = patch_cnt_q + PATCH_W'(1);
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (patch_cnt_q != PATCH_NUM) begin
                            state_d    = S_STREAM;
                            word_cnt_d = '0;
                        end else begin
                            state_d    = S_WAIT_READY;
                            wait_cnt_d = '0;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                S_WAIT_READY: begin
                    if (bus.all_cims_ready) begin
                        state_d = S_DONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are derived from the state being entered so they register in step with it.
        unique case (state_d)
            S_IDLE: begin
                busy_d      = 1'b0;
                word_cnt_d  = '0;
                patch_cnt_d = '0;
                gap_cnt_d   = '0;
                wait_cnt_d  = '0;
                rd_addr_d   = '0;
            end
            S_BCAST_START: begin
                drive_d   = 1'b1;
                op_d      = START_OP;
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
            end
            S_STREAM: begin
                drive_d  = 1'b1;
                op_d     = BCAST_OP;
                stream_d = 1'b1;
                rd_en_d  = (word_cnt_d != WORD_LAST);
            end
            S_GAP: begin
                drive_d = 1'b1;
                rd_en_d = (gap_cnt_d == GAP_LAST) && (patch_cnt_d != PATCH_NUM);
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase

        if (rd_en_d && state_d != S_BCAST_START)
            rd_addr_d = rd_addr_q + SAMPLE_ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            patch_cnt_q <= '0;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            drive_q     <= 1'b0;
            op_q        <= NOP_OP;
            stream_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            patch_cnt_q <= patch_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            drive_q     <= drive_d;
            op_q        <= op_d;
            stream_q    <= stream_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
        end
    end

    // Read data lands one cycle after the request, i.e. in the very cycle its OP word
    // is on the bus, so the sample lane is selected by a registered flag, not re-registered.
    assign bus.bus_data_write = {{(2*N_STORAGE){1'b0}},
                                 (stream_q ? bus.sample_rd_data : {N_STORAGE{1'b0}})};
    assign bus.sample_rd_en               = rd_en_q;
    assign bus.sample_rd_addr             = rd_addr_q;
    assign bus.bus_drive                  = drive_q;
    assign bus.bus_op_write               = op_q;
    assign bus.bus_target_or_sender_write = '0;
    assign busy                           = busy_q;
    assign done                           = done_q;
    assign timeout_err                    = terr_q;
endmodule

// File: tb/tb_patch_broadcaster.sv
// Directed bench for patch_broadcaster: PATCH_LEN=4, NUM_PATCHES=3, gap 2, timeout 8,
// sample memory holding mem[i]=i+1 with one-cycle read latency.
module tb_patch_broadcaster;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_START = 4'h5;
    localparam logic [3:0] OP_BCAST = 4'h6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, timeout_err;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_drv = 0;
    int   n_done = 0;
    int   drv0, done0;
    logic [15:0] mem [16];

    patch_broadcaster_if #(.N_STORAGE(16), .BUS_OP_WIDTH(4), .NUM_CIMS(64),
                           .SAMPLE_ADDR_W(4)) bus ();

    patch_broadcaster #(
        .PATCH_LEN(4), .NUM_PATCHES(3), .INTER_PATCH_GAP(2), .READY_TIMEOUT(8),
        .N_STORAGE(16), .BUS_OP_WIDTH(4), .NUM_CIMS(64), .SAMPLE_ADDR_W(4),
        .NOP_OP(OP_NOP), .START_OP(OP_START), .BCAST_OP(OP_BCAST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sample_rd_en === 1'b1) bus.sample_rd_data <= mem[bus.sample_rd_addr];
        if (bus.bus_drive === 1'b1) n_drv++;
        if (done === 1'b1) n_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drive"}, 64'(bus.bus_drive), 64'd0);
        chk({tag, "_op"}, 64'(bus.bus_op_write), 64'(OP_NOP));
        chk({tag, "_data"}, 64'(bus.bus_data_write), 64'd0);
        chk({tag, "_tgt"}, 64'(bus.bus_target_or_sender_write), 64'd0);
        chk({tag, "_rden"}, 64'(bus.sample_rd_en), 64'd0);
        chk({tag, "_addr"}, 64'(bus.sample_rd_addr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_terr"}, 64'(timeout_err), 64'd0);
    endtask

    // Starts a broadcast and checks all 19 driven cycles; ends on the last NOP cycle.
    // inj >= 0 raises start for one cycle during STREAM word number inj (0..11).
    task automatic bcast_check(input int inj);
        int k = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_op", 64'(bus.bus_op_write), 64'(OP_START));
        chk("start_drive", 64'(bus.bus_drive), 64'd1);
        chk("start_data", 64'(bus.bus_data_write), 64'd0);
        chk("start_rd", {63'd0, bus.sample_rd_en}, 64'd1);
        chk("start_addr", 64'(bus.sample_rd_addr), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                start = (k == inj);
                chk("word_drive", 64'(bus.bus_drive), 64'd1);
                chk("word_op", 64'(bus.bus_op_write), 64'(OP_BCAST));
                chk("word_data", 64'(bus.bus_data_write), 64'(p*4 + i + 1));
                chk("word_rden", 64'(bus.sample_rd_en), 64'(i < 3));
                if (i < 3) chk("word_addr", 64'(bus.sample_rd_addr), 64'(p*4 + i + 1));
                k++;
            end
            for (int g = 0; g < 2; g++) begin
                step();
                start = 1'b0;
                chk("gap_drive", 64'(bus.bus_drive), 64'd1);
                chk("gap_op", 64'(bus.bus_op_write), 64'(OP_NOP));
                chk("gap_data", 64'(bus.bus_data_write), 64'd0);
                chk("gap_rden", 64'(bus.sample_rd_en), 64'(g == 1 && p < 2));
                if (g == 1 && p < 2) chk("gap_addr", 64'(bus.sample_rd_addr), 64'((p+1)*4));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
        bus.all_cims_ready = 1'b0;
        bus.sample_rd_data = '0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;
        step();
        chk_reset_vals("idle");

        // Nominal run, ready rises 5 cycles after WAIT_READY entry.
        drv0 = n_drv; done0 = n_done;
        bcast_check(-1);
        step();
        chk("wait_drive", 64'(bus.bus_drive), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        for (int w = 1; w < 5; w++) begin
            step();
            chk("wait_nodone", 64'(done), 64'd0);
        end
        step();
        bus.all_cims_ready = 1'b1;
        chk("wait5_nodone", 64'(done), 64'd0);
        step();
        bus.all_cims_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        step();
        chk("after_done", 64'(done), 64'd0);
        chk("after_busy", 64'(busy), 64'd0);
        chk("drv_count", 64'(n_drv - drv0), 64'd19);
        chk("done_count", 64'(n_done - done0), 64'd1);

        // Timeout with ready held low.
        done0 = n_done;
        bcast_check(-1);
        for (int w = 0; w < 8; w++) begin
            step();
            chk("to_wait_busy", 64'(busy), 64'd1);
            chk("to_wait_terr", 64'(timeout_err), 64'd0);
        end
        step();
        chk("to_terr", 64'(timeout_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_nodone", 64'(n_done - done0), 64'd0);
        step();
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // Next start clears timeout_err; abort on the 3rd OP word of patch 1.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clr_terr", 64'(timeout_err), 64'd0);
        for (int s = 0; s < 9; s++) step();
        chk("ab_word", 64'(bus.bus_data_write), 64'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_drive", 64'(bus.bus_drive), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_rden", 64'(bus.sample_rd_en), 64'd0);
        chk("ab_op", 64'(bus.bus_op_write), 64'(OP_NOP));

        // start and abort together while IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 64'(busy), 64'd0);
        chk("sa_drive", 64'(bus.bus_drive), 64'd0);

        // Restart from address 0, then reset in the first GAP cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_addr", 64'(bus.sample_rd_addr), 64'd0);
        chk("rs_op", 64'(bus.bus_op_write), 64'(OP_START));
        step();
        chk("rs_word0", 64'(bus.bus_data_write), 64'd1);
        for (int s = 0; s < 4; s++) step();
        chk("gap_before_rst", 64'(bus.bus_drive), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midgap");
        @(negedge clk) rst_n = 1'b1;
        drv0 = n_drv;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("post_rst_drive", 64'(bus.bus_drive), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        chk("post_rst_drv", 64'(n_drv - drv0), 64'd0);

        // start during STREAM ignored; ready already high on WAIT_READY entry.
        drv0 = n_drv; done0 = n_done;
        bus.all_cims_ready = 1'b1;
        bcast_check(5);
        step();
        chk("rdy_wait_drive", 64'(bus.bus_drive), 64'd0);
        chk("rdy_wait_nodone", 64'(done), 64'd0);
        step();
        chk("rdy_done", 64'(done), 64'd1);
        step();
        bus.all_cims_ready = 1'b0;
        chk("rdy_idle", 64'(busy), 64'd0);
        for (int s = 0; s < 3; s++) step();
        chk("rdy_drv", 64'(n_drv - drv0), 64'd19);
        chk("rdy_done_cnt", 64'(n_done - done0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/patch_broadcaster.md
Name: patch_broadcaster

Overview:
- Master-side stage directly upstream of the CIM array.
- Streams raw EEG patch samples from sample memory onto the shared CIM bus, using PATCH_LOAD_BROADCAST_START_OP followed by PATCH_LOAD_BROADCAST_OP words.
- Inserts a NOP gap after each patch so every CIM can run its patch-projection MAC.
- After the last patch, releases the bus and waits for all CIMs to report is_ready before signalling done.

Parameters:
PATCH_LEN, 64, samples per patch (words per patch burst)
NUM_PATCHES, 60, patches per inference
INTER_PATCH_GAP, 96, NOP cycles driven after each patch burst (>=1)
READY_TIMEOUT, 4096, max cycles in WAIT_READY before error
N_STORAGE, 16, sample / bus word width
BUS_OP_WIDTH, 4, bus opcode width (op values from the shared bus op enum)
NUM_CIMS, 64, CIM count
SAMPLE_ADDR_W, $clog2(PATCH_LEN*NUM_PATCHES), sample memory address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a broadcast when IDLE
abort  in  1  synchronous abort; returns to IDLE
sample_rd_en  out  1  sample memory read enable
sample_rd_addr  out  SAMPLE_ADDR_W  sample memory read address
sample_rd_data  in  N_STORAGE  read data, valid exactly 1 cycle after sample_rd_en
all_cims_ready  in  1  AND of all CIM is_ready
bus_drive  out  1  tri-state enable for bus outputs
bus_op_write  out  BUS_OP_WIDTH  opcode
bus_data_write  out  3xN_STORAGE  data; [0]=sample, [1],[2]=0
bus_target_or_sender_write  out  $clog2(NUM_CIMS)  always 0 (broadcast)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on successful completion
timeout_err  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State IDLE; all counters 0.
  - bus_drive=0, bus_op_write=NOP, bus_data_write=0, target=0.
  - sample_rd_en=0, sample_rd_addr=0, busy=0, done=0, timeout_err=0.
  - Reset mid-burst releases the bus immediately; no partial words are resumed.
- States: IDLE, BCAST_START, STREAM, GAP, WAIT_READY, DONE. All outputs are registered.
- IDLE: start=1 -> BCAST_START next cycle; timeout_err cleared. start is ignored in all other states.
- BCAST_START (1 cycle):
  - bus_drive=1, op=PATCH_LOAD_BROADCAST_START_OP, data=0.
  - sample_rd_en=1, sample_rd_addr=0.
  - -> STREAM.
- STREAM:
  - Each cycle: bus_drive=1, op=PATCH_LOAD_BROADCAST_OP, bus_data_write[0]=sample_rd_data.
  - word_cnt increments each cycle; sample_rd_addr increments each cycle.
  - sample_rd_en=1 while more words in the current patch remain to be fetched.
  - Exactly PATCH_LEN consecutive OP cycles per patch; word i of patch p comes from address p*PATCH_LEN+i.
  - After word PATCH_LEN-1 -> GAP; word_cnt=0, patch_cnt increments.
- GAP:
  - bus_drive=1, op=NOP, data=0, for exactly INTER_PATCH_GAP cycles.
  - If patch_cnt<NUM_PATCHES: on the last gap cycle, assert sample_rd_en for the next patch's first address, then -> STREAM.
  - Otherwise -> WAIT_READY with no read issued.
- WAIT_READY:
  - bus_drive=0, sample_rd_en=0.
  - all_cims_ready=1 -> DONE.
  - Cycle counter reaching READY_TIMEOUT -> timeout_err=1, -> IDLE without done.
  - If all_cims_ready and timeout occur in the same cycle, ready wins.
- DONE (1 cycle): done=1, -> IDLE.
- abort:
  - Abort in any non-IDLE state -> IDLE next cycle with bus_drive=0 and counters cleared.
  - Abort takes priority over every other transition, including the DONE pulse (no done is produced).
  - start and abort in the same cycle while IDLE: abort wins and the start is dropped.
- Latency and cycle accounting:
  - start -> first START op on the bus: 1 cycle.
  - Bus-driven cycles per inference: 1 + NUM_PATCHES*(PATCH_LEN+INTER_PATCH_GAP). Defaults give 9601.
- Counters: word_cnt and patch_cnt never wrap within one broadcast; sample_rd_addr maximum is PATCH_LEN*NUM_PATCHES-1.

Test Plan:
- Params PATCH_LEN=4, NUM_PATCHES=3, INTER_PATCH_GAP=2; memory[i]=i+1; start; all_cims_ready asserted 5 cycles after WAIT_READY entry -> bus sequence is:
  - START op, OP words 1..4, NOP x2, OP words 5..8, NOP x2, OP words 9..12, NOP x2;
  - bus_drive then drops; done pulses 6 cycles after WAIT_READY entry; 19 driven cycles total.
- Same params, all_cims_ready held low, READY_TIMEOUT=8 -> timeout_err=1 after 8 WAIT_READY cycles, no done, busy=0. Next start clears timeout_err.
- abort asserted on the 3rd OP word of patch 1 -> next cycle bus_drive=0, busy=0, sample_rd_en=0. A following start restarts from address 0.
- rst_n asserted low mid-GAP -> bus_drive=0 and all outputs at reset values within the same cycle. After release, state is IDLE and no spontaneous bus activity occurs.
- start pulsed during STREAM -> ignored: the word sequence is identical to an unperturbed run and exactly one done pulse occurs.
- all_cims_ready already high on WAIT_READY entry -> done on the following cycle; no bus cycles after the final NOP.
